// File: rtl/mem_req_sched_pkg.sv
// Shared types for the L1-miss to main_mem request path and the scheduler FSM.
package mem_req_sched_pkg;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned BLOCK_ADDR_W = 28;
    localparam int unsigned BLOCK_DATA_W = 128;

    typedef logic [ADDR_W-1:0]       addr_t;
    typedef logic [BLOCK_ADDR_W-1:0] main_mem_block_addr_t;
    typedef logic [BLOCK_DATA_W-1:0] block_data_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } cache_type_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } req_type_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } req_width_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP
    } mem_sched_state_t;

endpackage

// File: rtl/mem_sched_arb.sv
// Requester select between icache and dcache, with a starvation counter that
// forces a dcache grant after STARVE_LIMIT icache grants while dcache waits.
module mem_sched_arb
    import mem_req_sched_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic icache_valid,
    input  logic dcache_valid,
    output logic icache_grant,
    output logic dcache_grant
);

    localparam int unsigned      CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;
    logic             pick_d;

    // Grants are also the ready signals, so they are held low during reset.
    always_comb begin
        starved      = (starve_cnt == CNT_MAX);
        pick_d       = dcache_valid && (!icache_valid || starved);
        dcache_grant = idle && !rst && pick_d;
        icache_grant = idle && !rst && icache_valid && !pick_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (idle) begin
            if (dcache_grant || !dcache_valid) begin
                starve_cnt <= '0;
            end else if (icache_grant && !starved) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_req_sched.sv
// One-at-a-time scheduler between icache/dcache misses and main_mem: registers a
// single request pulse, waits for the read response and routes it to its owner.
module mem_req_sched
    import mem_req_sched_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    icache_req_valid,
    input  logic [BLOCK_ADDR_W-1:0] icache_req_block_addr,
    output logic                    icache_req_ready,

    input  logic                    dcache_req_valid,
    input  logic                    dcache_req_type,
    input  logic [BLOCK_ADDR_W-1:0] dcache_req_block_addr,
    input  logic [BLOCK_DATA_W-1:0] dcache_req_block_data,
    input  logic [1:0]              dcache_req_width,
    input  logic [ADDR_W-1:0]       dcache_req_addr,
    output logic                    dcache_req_ready,

    output logic                    mem_req_valid,
    output logic                    mem_req_cache_type,
    output logic                    mem_req_type,
    output logic [BLOCK_ADDR_W-1:0] mem_req_block_addr,
    output logic [BLOCK_DATA_W-1:0] mem_req_block_data,
    output logic [1:0]              mem_req_width,
    output logic [ADDR_W-1:0]       mem_req_addr,

    input  logic                    mem_resp_valid,
    input  logic                    mem_resp_cache_type,
    input  logic [BLOCK_DATA_W-1:0] mem_resp_block_data,

    output logic                    icache_resp_valid,
    output logic [BLOCK_DATA_W-1:0] icache_resp_block_data,
    output logic                    dcache_resp_valid,
    output logic [BLOCK_DATA_W-1:0] dcache_resp_block_data,

    output logic                    busy,
    output logic                    err_spurious_resp
);

    mem_sched_state_t state, state_next;
    logic             in_idle;
    logic             icache_grant;
    logic             dcache_grant;
    logic             fwd;

    assign in_idle = (state == IDLE);

    mem_sched_arb #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .clk          (clk),
        .rst          (rst),
        .idle         (in_idle),
        .icache_valid (icache_req_valid),
        .dcache_valid (dcache_req_valid),
        .icache_grant (icache_grant),
        .dcache_grant (dcache_grant)
    );

    // The latched request fields double as the in-flight owner and type record.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_valid      <= 1'b0;
            mem_req_cache_type <= '0;
            mem_req_type       <= '0;
            mem_req_block_addr <= '0;
            mem_req_block_data <= '0;
            mem_req_width      <= '0;
            mem_req_addr       <= '0;
        end else begin
            mem_req_valid <= icache_grant || dcache_grant;
            if (dcache_grant) begin
                mem_req_cache_type <= DCACHE;
                mem_req_type       <= dcache_req_type;
                mem_req_block_addr <= dcache_req_block_addr;
                mem_req_block_data <= dcache_req_block_data;
                mem_req_width      <= dcache_req_width;
                mem_req_addr       <= dcache_req_addr;
            end else if (icache_grant) begin
                mem_req_cache_type <= ICACHE;
                mem_req_type       <= READ;
                mem_req_block_addr <= icache_req_block_addr;
                mem_req_block_data <= '0;
                mem_req_width      <= WORD;
                mem_req_addr       <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            err_spurious_resp <= 1'b0;
        end else begin
            state <= state_next;
            if (mem_resp_valid && !fwd) begin
                err_spurious_resp <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        fwd        = 1'b0;
        case (state)
            IDLE: begin
                if (icache_grant || dcache_grant) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = (mem_req_type == WRITE) ? IDLE : WAIT_RESP;
            end
            WAIT_RESP: begin
                if (mem_resp_valid && (mem_resp_cache_type == mem_req_cache_type)) begin
                    fwd        = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        icache_req_ready       = icache_grant;
        dcache_req_ready       = dcache_grant;
        busy                   = !in_idle;
        icache_resp_valid      = fwd && (mem_req_cache_type == ICACHE);
        dcache_resp_valid      = fwd && (mem_req_cache_type == DCACHE);
        icache_resp_block_data = icache_resp_valid ? mem_resp_block_data : '0;
        dcache_resp_block_data = dcache_resp_valid ? mem_resp_block_data : '0;
    end

endmodule

// File: tb/tb_mem_req_sched.sv
// Directed bench for mem_req_sched: transaction-level reference model checked every
// cycle, plus literal expectations for the hand-worked scenarios.
module tb_mem_req_sched;
    import mem_req_sched_pkg::*;

    localparam int LIMIT = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    icache_req_valid;
    logic [BLOCK_ADDR_W-1:0] icache_req_block_addr;
    logic                    icache_req_ready;
    logic                    dcache_req_valid;
    logic                    dcache_req_type;
    logic [BLOCK_ADDR_W-1:0] dcache_req_block_addr;
    logic [BLOCK_DATA_W-1:0] dcache_req_block_data;
    logic [1:0]              dcache_req_width;
    logic [ADDR_W-1:0]       dcache_req_addr;
    logic                    dcache_req_ready;
    logic                    mem_req_valid;
    logic                    mem_req_cache_type;
    logic                    mem_req_type;
    logic [BLOCK_ADDR_W-1:0] mem_req_block_addr;
    logic [BLOCK_DATA_W-1:0] mem_req_block_data;
    logic [1:0]              mem_req_width;
    logic [ADDR_W-1:0]       mem_req_addr;
    logic                    mem_resp_valid;
    logic                    mem_resp_cache_type;
    logic [BLOCK_DATA_W-1:0] mem_resp_block_data;
    logic                    icache_resp_valid;
    logic [BLOCK_DATA_W-1:0] icache_resp_block_data;
    logic                    dcache_resp_valid;
    logic [BLOCK_DATA_W-1:0] dcache_resp_block_data;
    logic                    busy;
    logic                    err_spurious_resp;

    int n_checks = 0;
    int n_pass   = 0;

    mem_req_sched #(
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .icache_req_valid       (icache_req_valid),
        .icache_req_block_addr  (icache_req_block_addr),
        .icache_req_ready       (icache_req_ready),
        .dcache_req_valid       (dcache_req_valid),
        .dcache_req_type        (dcache_req_type),
        .dcache_req_block_addr  (dcache_req_block_addr),
        .dcache_req_block_data  (dcache_req_block_data),
        .dcache_req_width       (dcache_req_width),
        .dcache_req_addr        (dcache_req_addr),
        .dcache_req_ready       (dcache_req_ready),
        .mem_req_valid          (mem_req_valid),
        .mem_req_cache_type     (mem_req_cache_type),
        .mem_req_type           (mem_req_type),
        .mem_req_block_addr     (mem_req_block_addr),
        .mem_req_block_data     (mem_req_block_data),
        .mem_req_width          (mem_req_width),
        .mem_req_addr           (mem_req_addr),
        .mem_resp_valid         (mem_resp_valid),
        .mem_resp_cache_type    (mem_resp_cache_type),
        .mem_resp_block_data    (mem_resp_block_data),
        .icache_resp_valid      (icache_resp_valid),
        .icache_resp_block_data (icache_resp_block_data),
        .dcache_resp_valid      (dcache_resp_valid),
        .dcache_resp_block_data (dcache_resp_block_data),
        .busy                   (busy),
        .err_spurious_resp      (err_spurious_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [BLOCK_DATA_W-1:0] act,
                         input logic [BLOCK_DATA_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: accepting / pulse pending / awaiting response, as a transaction view.
    bit                      m_accept  = 1'b1;
    bit                      m_pulse   = 1'b0;
    bit                      m_waiting = 1'b0;
    bit                      m_err     = 1'b0;
    int                      m_streak  = 0;
    logic                    m_ct      = 1'b0;
    logic                    m_type    = 1'b0;
    logic [BLOCK_ADDR_W-1:0] m_baddr   = '0;
    logic [BLOCK_DATA_W-1:0] m_data    = '0;
    logic [1:0]              m_width   = '0;
    logic [ADDR_W-1:0]       m_addr    = '0;

    always @(negedge clk) begin : model_cmp
        logic pick_d, e_iready, e_dready, e_fwd, was_accept;
        if (rst) begin
            m_accept = 1'b1; m_pulse = 1'b0; m_waiting = 1'b0; m_err = 1'b0; m_streak = 0;
            m_ct = 1'b0; m_type = 1'b0; m_baddr = '0; m_data = '0; m_width = '0; m_addr = '0;
        end
        pick_d   = dcache_req_valid && (!icache_req_valid || m_streak == LIMIT);
        e_dready = !rst && m_accept && pick_d;
        e_iready = !rst && m_accept && icache_req_valid && !pick_d;
        e_fwd    = !rst && m_waiting && mem_resp_valid && (mem_resp_cache_type == m_ct);

        check("m_iready", icache_req_ready, e_iready);
        check("m_dready", dcache_req_ready, e_dready);
        check("m_req_valid", mem_req_valid, m_pulse);
        check("m_req_ct", mem_req_cache_type, m_ct);
        check("m_req_type", mem_req_type, m_type);
        check("m_req_baddr", mem_req_block_addr, m_baddr);
        check("m_req_data", mem_req_block_data, m_data);
        check("m_req_width", mem_req_width, m_width);
        check("m_req_addr", mem_req_addr, m_addr);
        check("m_iresp_valid", icache_resp_valid, e_fwd && m_ct == ICACHE);
        check("m_iresp_data", icache_resp_block_data,
              (e_fwd && m_ct == ICACHE) ? mem_resp_block_data : '0);
        check("m_dresp_valid", dcache_resp_valid, e_fwd && m_ct == DCACHE);
        check("m_dresp_data", dcache_resp_block_data,
              (e_fwd && m_ct == DCACHE) ? mem_resp_block_data : '0);
        check("m_busy", busy, !m_accept);
        check("m_err", err_spurious_resp, m_err);

        if (!rst) begin
            was_accept = m_accept;
            if (m_pulse) begin
                m_pulse = 1'b0;
                if (m_type == READ) m_waiting = 1'b1;
                else m_accept = 1'b1;
            end
            if (e_fwd) begin
                m_waiting = 1'b0;
                m_accept  = 1'b1;
            end
            if (mem_resp_valid && !e_fwd) m_err = 1'b1;
            if (e_dready) begin
                m_streak = 0; m_accept = 1'b0; m_pulse = 1'b1;
                m_ct = DCACHE; m_type = dcache_req_type; m_baddr = dcache_req_block_addr;
                m_data = dcache_req_block_data; m_width = dcache_req_width; m_addr = dcache_req_addr;
            end else if (e_iready) begin
                m_streak = dcache_req_valid ? ((m_streak < LIMIT) ? m_streak + 1 : LIMIT) : 0;
                m_accept = 1'b0; m_pulse = 1'b1;
                m_ct = ICACHE; m_type = READ; m_baddr = icache_req_block_addr;
                m_data = '0; m_width = WORD; m_addr = '0;
            end else if (was_accept && !dcache_req_valid) begin
                m_streak = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input logic ct, input logic [BLOCK_DATA_W-1:0] d);
        mem_resp_valid      = 1'b1;
        mem_resp_cache_type = ct;
        mem_resp_block_data = d;
    endtask

    task automatic clear_resp();
        mem_resp_valid      = 1'b0;
        mem_resp_cache_type = 1'b0;
        mem_resp_block_data = '0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        string order;
        logic  owner;
        int    waited;
        rst = 1'b1;
        icache_req_valid = 1'b0; icache_req_block_addr = '0;
        dcache_req_valid = 1'b0; dcache_req_type = READ; dcache_req_block_addr = '0;
        dcache_req_block_data = '0; dcache_req_width = '0; dcache_req_addr = '0;
        clear_resp();
        tick();
        icache_req_valid = 1'b1;
        #2;
        check("rst_iready", icache_req_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_req_valid", mem_req_valid, 1'b0);
        check("rst_err", err_spurious_resp, 1'b0);
        tick();
        icache_req_valid = 1'b0;
        rst = 1'b0;
        tick();

        // 1: icache read, response three cycles after the pulse
        icache_req_valid = 1'b1; icache_req_block_addr = 'h10;
        #2;
        check("t1_iready_N", icache_req_ready, 1'b1);
        check("t1_busy_N", busy, 1'b0);
        tick(); icache_req_valid = 1'b0;
        #2;
        check("t1_pulse", mem_req_valid, 1'b1);
        check("t1_ct", mem_req_cache_type, ICACHE);
        check("t1_type", mem_req_type, READ);
        check("t1_baddr", mem_req_block_addr, 'h10);
        check("t1_width", mem_req_width, WORD);
        check("t1_busy_N1", busy, 1'b1);
        tick(); #2;
        check("t1_pulse_end", mem_req_valid, 1'b0);
        tick(); tick();
        respond(ICACHE, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        #2;
        check("t1_iresp_N4", icache_resp_valid, 1'b1);
        check("t1_idata_N4", icache_resp_block_data, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        check("t1_dresp_N4", dcache_resp_valid, 1'b0);
        check("t1_busy_N4", busy, 1'b1);
        tick(); clear_resp();
        #2;
        check("t1_busy_N5", busy, 1'b0);

        // 2: dcache write, no response, idle two cycles after handshake
        tick();
        dcache_req_valid = 1'b1; dcache_req_type = WRITE; dcache_req_block_addr = 'h20;
        dcache_req_block_data = {16{8'hAB}}; dcache_req_width = HALF; dcache_req_addr = 'h82;
        #2;
        check("t2_dready", dcache_req_ready, 1'b1);
        check("t2_iready", icache_req_ready, 1'b0);
        tick(); dcache_req_valid = 1'b0;
        #2;
        check("t2_pulse", mem_req_valid, 1'b1);
        check("t2_ct", mem_req_cache_type, DCACHE);
        check("t2_type", mem_req_type, WRITE);
        check("t2_baddr", mem_req_block_addr, 'h20);
        check("t2_data", mem_req_block_data, {16{8'hAB}});
        check("t2_width", mem_req_width, HALF);
        check("t2_addr", mem_req_addr, 'h82);
        tick(); #2;
        check("t2_busy_N2", busy, 1'b0);
        check("t2_pulse_end", mem_req_valid, 1'b0);
        check("t2_no_dresp", dcache_resp_valid, 1'b0);

        // 6: both idle, then dcache read only
        tick(); tick();
        dcache_req_valid = 1'b1; dcache_req_type = READ; dcache_req_block_addr = 'h30;
        dcache_req_block_data = '0; dcache_req_width = WORD; dcache_req_addr = 'h0;
        #2;
        check("t6_dready", dcache_req_ready, 1'b1);
        tick(); dcache_req_valid = 1'b0;
        tick();
        respond(DCACHE, 128'hD00D);
        #2;
        check("t6_dresp", dcache_resp_valid, 1'b1);
        check("t6_ddata", dcache_resp_block_data, 128'hD00D);
        check("t6_iresp", icache_resp_valid, 1'b0);
        tick(); clear_resp();

        // 3: both valid continuously, record grant order
        icache_req_valid = 1'b1; icache_req_block_addr = 'h40;
        dcache_req_valid = 1'b1; dcache_req_type = READ; dcache_req_block_addr = 'h50;
        order = "";
        for (int g = 0; g < 10; g++) begin
            waited = 0;
            #2;
            while (!icache_req_ready && !dcache_req_ready && waited < 8) begin
                tick(); #2; waited++;
            end
            check("t3_grant_seen", icache_req_ready || dcache_req_ready, 1'b1);
            owner = dcache_req_ready ? DCACHE : ICACHE;
            order = {order, (owner == DCACHE) ? "D" : "I"};
            tick(); tick();
            respond(owner, BLOCK_DATA_W'(g + 1));
            tick(); clear_resp();
        end
        icache_req_valid = 1'b0; dcache_req_valid = 1'b0;
        n_checks++;
        if (order == "IIIIDIIIID") n_pass++;
        else $display("FAIL t3_order: actual %s required IIIIDIIIID", order);

        // 4: spurious responses
        tick();
        respond(DCACHE, 128'hBAD);
        #2;
        check("t4_idle_iresp", icache_resp_valid, 1'b0);
        check("t4_idle_dresp", dcache_resp_valid, 1'b0);
        tick(); clear_resp();
        #2;
        check("t4_err_set", err_spurious_resp, 1'b1);
        icache_req_valid = 1'b1; icache_req_block_addr = 'h60;
        tick(); icache_req_valid = 1'b0;
        tick();
        respond(DCACHE, 128'hBAD2);
        #2;
        check("t4_mis_dresp", dcache_resp_valid, 1'b0);
        check("t4_mis_iresp", icache_resp_valid, 1'b0);
        tick(); clear_resp();
        #2;
        check("t4_still_busy", busy, 1'b1);
        check("t4_err_held", err_spurious_resp, 1'b1);
        tick();
        respond(ICACHE, 128'h600D);
        #2;
        check("t4_iresp", icache_resp_valid, 1'b1);
        tick(); clear_resp();
        #2;
        check("t4_idle_after", busy, 1'b0);

        // 5: reset while waiting for a response
        icache_req_valid = 1'b1; icache_req_block_addr = 'h70;
        tick(); icache_req_valid = 1'b0;
        tick();
        rst = 1'b1; icache_req_valid = 1'b1; icache_req_block_addr = 'h74;
        #2;
        check("t5_busy", busy, 1'b0);
        check("t5_req_valid", mem_req_valid, 1'b0);
        check("t5_baddr", mem_req_block_addr, '0);
        check("t5_err", err_spurious_resp, 1'b0);
        check("t5_iready", icache_req_ready, 1'b0);
        tick(); rst = 1'b0;
        #2;
        check("t5_iready_after", icache_req_ready, 1'b1);
        tick(); icache_req_valid = 1'b0;
        #2;
        check("t5_pulse", mem_req_valid, 1'b1);
        check("t5_pulse_baddr", mem_req_block_addr, 'h74);
        tick(); tick();
        respond(ICACHE, 128'h7474);
        #2;
        check("t5_iresp", icache_resp_valid, 1'b1);
        tick(); clear_resp();
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
